cv32e40px_x_result_tracker: RTL

In-order tracker and result buffer for instructions offloaded over the CV-X-IF interface. It sits between the core's issue/commit/result handshakes and the register-file writeback port. It records every accepted offload in issue order and collects the commit/kill decision and coprocessor result per ID. It releases results to writeback strictly in issue order, with single or dual register writes. It generalises the fixed single-ID X-interface types to a configurable outstanding depth, ID width, and dual-write width.

---
 rtl/cv32e40px_x_result_tracker.sv | 209 ++++++++++++++++++++
 1 files changed

// File: rtl/cv32e40px_x_result_tracker.sv
// In-order tracker and result buffer for CV-X-IF offloads: records issue order,
// collects commit/kill decisions and results per ID, retires to writeback in order.
module cv32e40px_x_result_tracker #(
    parameter int ID_WIDTH  = 4,
    parameter int DEPTH     = 4,
    parameter int DUALWRITE = 1,
    parameter int RFW_WIDTH = 32
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic                                issue_valid_i,
    output logic                                issue_ready_o,
    input  logic [ID_WIDTH-1:0]                 issue_id_i,
    input  logic                                issue_writeback_i,
    input  logic                                commit_valid_i,
    input  logic [ID_WIDTH-1:0]                 commit_id_i,
    input  logic                                commit_kill_i,
    input  logic                                result_valid_i,
    output logic                                result_ready_o,
    input  logic [ID_WIDTH-1:0]                 result_id_i,
    input  logic [(DUALWRITE+1)*RFW_WIDTH-1:0]  result_data_i,
    input  logic [(DUALWRITE+1)*5-1:0]          result_rd_i,
    input  logic [DUALWRITE:0]                  result_we_i,
    input  logic                                result_exc_i,
    input  logic [5:0]                          result_exccode_i,
    output logic                                wb_valid_o,
    input  logic                                wb_ready_i,
    output logic [ID_WIDTH-1:0]                 wb_id_o,
    output logic [(DUALWRITE+1)*RFW_WIDTH-1:0]  wb_data_o,
    output logic [(DUALWRITE+1)*5-1:0]          wb_rd_o,
    output logic [DUALWRITE:0]                  wb_we_o,
    output logic                                wb_exc_o,
    output logic [5:0]                          wb_exccode_o,
    output logic [$clog2(DEPTH):0]              outstanding_o,
    output logic                                spurious_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int NP = DUALWRITE + 1;
    localparam int DW = NP * RFW_WIDTH;
    localparam int RW = NP * 5;

    // Entry storage
    logic [DEPTH-1:0]    valid_q, wb_q, com_q, kill_q, hr_q, exc_q;
    logic [ID_WIDTH-1:0] id_q   [DEPTH];
    logic [DW-1:0]       data_q [DEPTH];
    logic [RW-1:0]       rd_q   [DEPTH];
    logic [NP-1:0]       we_q   [DEPTH];
    logic [5:0]          code_q [DEPTH];

    logic [AW:0] head_q, head_d, tail_q;

    // Registered writeback stage
    logic                wb_valid_q, wb_valid_d;
    logic [ID_WIDTH-1:0] wb_id_q, wb_id_d;
    logic [DW-1:0]       wb_data_q, wb_data_d;
    logic [RW-1:0]       wb_rd_q, wb_rd_d;
    logic [NP-1:0]       wb_we_q, wb_we_d;
    logic                wb_exc_q, wb_exc_d;
    logic [5:0]          wb_code_q, wb_code_d;
    logic                spurious_q, spurious_d;

    logic [AW-1:0] head_lo_s, tail_lo_s, nxt_lo_s;
    logic [AW-1:0] slot_s [DEPTH];
    logic          full_s, issue_fire_s;
    logic          pop_wb_s, pop_kill_s, pop_s, hold_s, nxt_ready_s;
    logic          cmatch_s, rmatch_s;
    logic [AW-1:0] cidx_s, ridx_s;

    assign head_lo_s      = head_q[AW-1:0];
    assign tail_lo_s      = tail_q[AW-1:0];
    assign full_s         = (head_lo_s == tail_lo_s) && (head_q[AW] != tail_q[AW]);
    assign issue_ready_o  = !full_s;
    assign issue_fire_s   = issue_valid_i && !full_s;
    assign result_ready_o = !rst;
    assign outstanding_o  = tail_q - head_q;

    assign wb_valid_o   = wb_valid_q;
    assign wb_id_o      = wb_id_q;
    assign wb_data_o    = wb_data_q;
    assign wb_rd_o      = wb_rd_q;
    assign wb_we_o      = wb_we_q;
    assign wb_exc_o     = wb_exc_q;
    assign wb_exccode_o = wb_code_q;
    assign spurious_o   = spurious_q;

    // Buffer slots in age order, oldest first
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            slot_s[i] = head_lo_s + AW'(i);
        end
    end

    // Oldest-first ID match for commit and result; scanning youngest to oldest lets the oldest win
    always_comb begin
        cmatch_s = 1'b0;
        rmatch_s = 1'b0;
        cidx_s   = {AW{1'b0}};
        ridx_s   = {AW{1'b0}};
        for (int i = DEPTH - 1; i >= 0; i--) begin
            cidx_s   = (valid_q[slot_s[i]] && (id_q[slot_s[i]] == commit_id_i)) ? slot_s[i] : cidx_s;
            cmatch_s = cmatch_s | (valid_q[slot_s[i]] && (id_q[slot_s[i]] == commit_id_i));
            ridx_s   = (valid_q[slot_s[i]] && (id_q[slot_s[i]] == result_id_i)) ? slot_s[i] : ridx_s;
            rmatch_s = rmatch_s | (valid_q[slot_s[i]] && (id_q[slot_s[i]] == result_id_i));
        end
        spurious_d = (commit_valid_i && !cmatch_s) || (result_valid_i && !rmatch_s);
    end

    // Head retire and next writeback-stage contents, taken from the entry that will be head next cycle
    always_comb begin
        pop_wb_s    = wb_valid_q && wb_ready_i;
        pop_kill_s  = valid_q[head_lo_s] && kill_q[head_lo_s];
        pop_s       = pop_wb_s || pop_kill_s;
        hold_s      = wb_valid_q && !wb_ready_i;
        head_d      = head_q + {{AW{1'b0}}, pop_s};
        nxt_lo_s    = head_d[AW-1:0];
        nxt_ready_s = valid_q[nxt_lo_s] && com_q[nxt_lo_s] && hr_q[nxt_lo_s];
        if (hold_s) begin
            wb_valid_d = wb_valid_q;
            wb_id_d    = wb_id_q;
            wb_data_d  = wb_data_q;
            wb_rd_d    = wb_rd_q;
            wb_we_d    = wb_we_q;
            wb_exc_d   = wb_exc_q;
            wb_code_d  = wb_code_q;
        end else if (nxt_ready_s) begin
            wb_valid_d = 1'b1;
            wb_id_d    = id_q[nxt_lo_s];
            wb_data_d  = data_q[nxt_lo_s];
            wb_rd_d    = rd_q[nxt_lo_s];
            wb_we_d    = wb_q[nxt_lo_s] ? we_q[nxt_lo_s] : {NP{1'b0}};
            wb_exc_d   = exc_q[nxt_lo_s];
            wb_code_d  = code_q[nxt_lo_s];
        end else begin
            wb_valid_d = 1'b0;
            wb_id_d    = {ID_WIDTH{1'b0}};
            wb_data_d  = {DW{1'b0}};
            wb_rd_d    = {RW{1'b0}};
            wb_we_d    = {NP{1'b0}};
            wb_exc_d   = 1'b0;
            wb_code_d  = 6'd0;
        end
    end

    // State update: pop, commit/kill, result capture, issue allocation
    always_ff @(posedge clk) begin
        if (rst) begin
            head_q     <= {(AW+1){1'b0}};
            tail_q     <= {(AW+1){1'b0}};
            valid_q    <= {DEPTH{1'b0}};
            wb_q       <= {DEPTH{1'b0}};
            com_q      <= {DEPTH{1'b0}};
            kill_q     <= {DEPTH{1'b0}};
            hr_q       <= {DEPTH{1'b0}};
            exc_q      <= {DEPTH{1'b0}};
            wb_valid_q <= 1'b0;
            wb_id_q    <= {ID_WIDTH{1'b0}};
            wb_data_q  <= {DW{1'b0}};
            wb_rd_q    <= {RW{1'b0}};
            wb_we_q    <= {NP{1'b0}};
            wb_exc_q   <= 1'b0;
            wb_code_q  <= 6'd0;
            spurious_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                id_q[i]   <= {ID_WIDTH{1'b0}};
                data_q[i] <= {DW{1'b0}};
                rd_q[i]   <= {RW{1'b0}};
                we_q[i]   <= {NP{1'b0}};
                code_q[i] <= 6'd0;
            end
        end else begin
            head_q     <= head_d;
            wb_valid_q <= wb_valid_d;
            wb_id_q    <= wb_id_d;
            wb_data_q  <= wb_data_d;
            wb_rd_q    <= wb_rd_d;
            wb_we_q    <= wb_we_d;
            wb_exc_q   <= wb_exc_d;
            wb_code_q  <= wb_code_d;
            spurious_q <= spurious_d;
            if (pop_s) begin
                valid_q[head_lo_s] <= 1'b0;
            end
            // Only the first decision for an entry takes effect
            if (commit_valid_i && cmatch_s && !com_q[cidx_s] && !kill_q[cidx_s]) begin
                com_q[cidx_s]  <= !commit_kill_i;
                kill_q[cidx_s] <= commit_kill_i;
            end
            if (result_valid_i && rmatch_s) begin
                hr_q[ridx_s]   <= 1'b1;
                data_q[ridx_s] <= result_data_i;
                rd_q[ridx_s]   <= result_rd_i;
                we_q[ridx_s]   <= result_we_i;
                exc_q[ridx_s]  <= result_exc_i;
                code_q[ridx_s] <= result_exccode_i;
            end
            if (issue_fire_s) begin
                valid_q[tail_lo_s] <= 1'b1;
                id_q[tail_lo_s]    <= issue_id_i;
                wb_q[tail_lo_s]    <= issue_writeback_i;
                com_q[tail_lo_s]   <= 1'b0;
                kill_q[tail_lo_s]  <= 1'b0;
                hr_q[tail_lo_s]    <= 1'b0;
                tail_q             <= tail_q + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule
